stage_2_ctrl: RTL and testbench

- Sequencing controller for the stage-2 range-update/normalization datapath, which is purely combinational.
- Owns the range feedback register: feeds the current range to the datapath and captures the normalized range returned.
- Accepts symbols with a valid/ready handshake and registers the datapath results into a one-entry output stage for the low/carry stage downstream.
- Handles frame end: after the last symbol it emits a flush token and re-initializes the range.

---
 rtl/entropy_encoder_pkg.sv | 26 ++
 rtl/stage_2_out_reg.sv | 30 +++
 rtl/stage_2_ctrl.sv | 127 ++++++++++++
 tb/tb_stage_2_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/entropy_encoder_pkg.sv
// Shared constants, FSM encoding and output-token layout for the stage-2 range-update controller.
package entropy_encoder_pkg;

  localparam int RANGE_WIDTH = 16;
  localparam int D_SIZE      = 5;
  localparam logic [RANGE_WIDTH-1:0] INIT_RANGE = 16'h8000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [RANGE_WIDTH:0]   u;
    logic [RANGE_WIDTH:0]   v_bool;
    logic [RANGE_WIDTH-1:0] initial_range;
    logic [D_SIZE-1:0]      d;
    logic [1:0]             bool_symbol;
    logic                   comp_mux_1;
    logic                   last;
    logic                   flush;
  } token_t;

  localparam int TOKEN_W = $bits(token_t);

endpackage

// File: rtl/stage_2_out_reg.sv
// One-entry valid/ready holding register: loads a token when told to, holds it until drained.
module stage_2_out_reg
  import entropy_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TOKEN_W-1:0] data,
  input  logic               out_ready,
  output logic               valid,
  output logic               free,
  output logic [TOKEN_W-1:0] q
);

  assign free = !valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_2_ctrl.sv
// Stage-2 sequencing controller: range feedback register, accept handshake, frame flush.
// Optional statistics counters are enabled by defining STAGE_2_CTRL_STATS_EN.
module stage_2_ctrl
  import entropy_encoder_pkg::*;
#(
  parameter int RANGE_WIDTH = entropy_encoder_pkg::RANGE_WIDTH,
  parameter int D_SIZE      = entropy_encoder_pkg::D_SIZE,
  parameter logic [RANGE_WIDTH-1:0] INIT_RANGE = entropy_encoder_pkg::INIT_RANGE,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [RANGE_WIDTH-1:0] dp_in_range,
  input  logic [RANGE_WIDTH-1:0] dp_out_range,
  input  logic [D_SIZE-1:0]      dp_d,
  input  logic [RANGE_WIDTH:0]   dp_u,
  input  logic [RANGE_WIDTH:0]   dp_v_bool,
  input  logic [1:0]             dp_bool_symbol,
  input  logic                   dp_comp_mux_1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RANGE_WIDTH:0]   out_u,
  output logic [RANGE_WIDTH:0]   out_v_bool,
  output logic [RANGE_WIDTH-1:0] out_initial_range,
  output logic [D_SIZE-1:0]      out_d,
  output logic [1:0]             out_bool_symbol,
  output logic                   out_comp_mux_1,
  output logic                   out_last,
  output logic                   out_flush,
  output logic [CNT_WIDTH-1:0]   sym_count,
`ifdef STAGE_2_CTRL_STATS_EN
  output logic [31:0]            stall_cycles,
  output logic [31:0]            shift_total,
`endif
  output logic                   err_zero_range
);

  state_e                 state;
  logic [RANGE_WIDTH-1:0] range_reg;
  logic                   out_free;
  logic                   accept;
  logic                   flush_load;
  token_t                 tok_next;
  token_t                 tok_q;
  logic [TOKEN_W-1:0]     q_bits;

  assign dp_in_range = range_reg;
  assign in_ready    = (state == RUN) && out_free;
  assign accept      = in_valid && in_ready;
  assign flush_load  = (state == FLUSH) && out_free;

  // NOTE: always_comb assigns a default first so no path leaves a variable unassigned (no latch).
  always_comb begin
    tok_next = '0;
    if (accept) begin
      tok_next.u             = dp_u;
      tok_next.v_bool        = dp_v_bool;
      tok_next.initial_range = range_reg;
      tok_next.d             = dp_d;
      tok_next.bool_symbol   = dp_bool_symbol;
      tok_next.comp_mux_1    = dp_comp_mux_1;
      tok_next.last          = in_last;
    end else begin
      tok_next.flush         = 1'b1;
    end
  end

  stage_2_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept || flush_load),
    .data      (tok_next),
    .out_ready (out_ready),
    .valid     (out_valid),
    .free      (out_free),
    .q         (q_bits)
  );

  assign tok_q             = token_t'(q_bits);
  assign out_u             = tok_q.u;
  assign out_v_bool        = tok_q.v_bool;
  assign out_initial_range = tok_q.initial_range;
  assign out_d             = tok_q.d;
  assign out_bool_symbol   = tok_q.bool_symbol;
  assign out_comp_mux_1    = tok_q.comp_mux_1;
  assign out_last          = tok_q.last;
  assign out_flush         = tok_q.flush;

  // A zero range would freeze the encoder, so it is replaced by INIT_RANGE and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      range_reg      <= INIT_RANGE;
      sym_count      <= '0;
      err_zero_range <= 1'b0;
    end else if (accept) begin
      range_reg <= (dp_out_range == '0) ? INIT_RANGE : dp_out_range;
      if (dp_out_range == '0) err_zero_range <= 1'b1;
      if (sym_count != '1) sym_count <= sym_count + CNT_WIDTH'(1);
      if (in_last) state <= FLUSH;
    end else if (flush_load) begin
      range_reg <= INIT_RANGE;
      sym_count <= '0;
      state     <= RUN;
    end
  end

`ifdef STAGE_2_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      shift_total  <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (accept) begin
        if ({1'b0, shift_total} + 33'(dp_d) > 33'hFFFF_FFFF) shift_total <= '1;
        else shift_total <= shift_total + 32'(dp_d);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage_2_ctrl.sv
// Directed bench for stage_2_ctrl with a token scoreboard and a small cycle model.
module tb_stage_2_ctrl;

  localparam logic [15:0] INIT = 16'h8000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, in_ready;
  logic [15:0] dp_in_range, dp_out_range;
  logic [4:0]  dp_d;
  logic [16:0] dp_u, dp_v_bool;
  logic [1:0]  dp_bool_symbol;
  logic        dp_comp_mux_1;
  logic        out_valid, out_ready;
  logic [16:0] out_u, out_v_bool;
  logic [15:0] out_initial_range;
  logic [4:0]  out_d;
  logic [1:0]  out_bool_symbol;
  logic        out_comp_mux_1, out_last, out_flush;
  logic [15:0] sym_count;
  logic        err_zero_range;
`ifdef STAGE_2_CTRL_STATS_EN
  logic [31:0] stall_cycles, shift_total;
`endif

  stage_2_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .dp_in_range       (dp_in_range),
    .dp_out_range      (dp_out_range),
    .dp_d              (dp_d),
    .dp_u              (dp_u),
    .dp_v_bool         (dp_v_bool),
    .dp_bool_symbol    (dp_bool_symbol),
    .dp_comp_mux_1     (dp_comp_mux_1),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_u             (out_u),
    .out_v_bool        (out_v_bool),
    .out_initial_range (out_initial_range),
    .out_d             (out_d),
    .out_bool_symbol   (out_bool_symbol),
    .out_comp_mux_1    (out_comp_mux_1),
    .out_last          (out_last),
    .out_flush         (out_flush),
    .sym_count         (sym_count),
`ifdef STAGE_2_CTRL_STATS_EN
    .stall_cycles      (stall_cycles),
    .shift_total       (shift_total),
`endif
    .err_zero_range    (err_zero_range)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state and token scoreboard.
  logic [63:0] sb[$];
  bit          m_ov, m_flush, m_err;
  logic [15:0] m_range, m_count;
  int unsigned m_stall, m_shift;
  int          step_no = 0;

  function automatic logic [63:0] dut_tok();
    return 64'({out_u, out_v_bool, out_initial_range, out_d, out_bool_symbol,
                out_comp_mux_1, out_last, out_flush});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    dp_out_range = 16'h1234; dp_d = '0; dp_u = '0; dp_v_bool = '0;
    dp_bool_symbol = '0; dp_comp_mux_1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_ov = 0; m_flush = 0; m_err = 0; m_range = INIT; m_count = 0;
    m_stall = 0; m_shift = 0;
    #1;
    check("rst_dp_in_range", dp_in_range, INIT);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sym_count", sym_count, 0);
    check("rst_out_fields", dut_tok(), 0);
    check("rst_err", err_zero_range, 0);
  endtask

  // One clock cycle: drive after the falling edge, check settled outputs, advance the model.
  task automatic cycle(input bit iv, input bit il, input bit ordy,
                       input logic [15:0] rng, input logic [4:0] d);
    bit free, exp_rdy, acc;
    @(negedge clk);
    step_no++;
    in_valid = iv; in_last = il; out_ready = ordy; dp_out_range = rng; dp_d = d;
    dp_u = 17'(step_no * 37 + 5);
    dp_v_bool = 17'(step_no * 91 + 3);
    dp_bool_symbol = 2'(step_no);
    dp_comp_mux_1 = step_no[2];
    #1;
    free    = !m_ov || ordy;
    exp_rdy = !m_flush && free;
    check("in_ready", in_ready, exp_rdy);
    check("dp_in_range", dp_in_range, m_range);
    check("out_valid", out_valid, m_ov);
    check("sym_count", sym_count, m_count);
    check("err_zero_range", err_zero_range, m_err);
    if (m_ov) begin
      if (sb.size() == 0) check("sb_underflow", 0, 1);
      else check("out_token", dut_tok(), sb[0]);
      if (ordy) begin
        void'(sb.pop_front());
        m_ov = 0;
      end
    end
    acc = iv && exp_rdy;
    if (iv && !exp_rdy) m_stall++;
    if (acc) begin
      sb.push_back(64'({dp_u, dp_v_bool, m_range, d, dp_bool_symbol, dp_comp_mux_1, il, 1'b0}));
      m_ov = 1;
      m_shift += d;
      if (rng == 0) m_err = 1;
      m_range = (rng == 0) ? INIT : rng;
      m_count++;
      m_flush = il;
    end else if (m_flush && free) begin
      sb.push_back(64'h1);
      m_ov = 1;
      m_range = INIT;
      m_count = 0;
      m_flush = 0;
    end
  endtask

  initial begin
    do_reset();

    // Single symbol, then observe it next cycle.
    cycle(1, 0, 1, 16'hA000, 5'd1);
    cycle(0, 0, 0, 16'h0F0F, 5'd0);
    check("first_initial_range", out_initial_range, INIT);
    check("first_out_d", out_d, 1);

    // Back-pressure for three cycles, then release with a same-cycle accept.
    cycle(1, 0, 0, 16'hB000, 5'd2);
    cycle(1, 0, 0, 16'hB000, 5'd2);
    cycle(1, 0, 0, 16'hB000, 5'd2);
    cycle(1, 0, 1, 16'hB000, 5'd2);

    // Three-symbol frame ending in last, then flush token.
    cycle(1, 0, 1, 16'hC000, 5'd3);
    cycle(1, 0, 1, 16'hD000, 5'd4);
    cycle(1, 1, 1, 16'hE000, 5'd5);
    cycle(1, 0, 1, 16'h7777, 5'd6);
    cycle(0, 0, 1, 16'h0000, 5'd0);
    cycle(0, 0, 1, 16'h0000, 5'd0);

    // Zero range is flagged and replaced by the initial range.
    cycle(1, 0, 1, 16'h0000, 5'd7);
    cycle(1, 0, 1, 16'h9000, 5'd1);
    cycle(0, 0, 1, 16'h0000, 5'd0);
    cycle(0, 0, 1, 16'h0000, 5'd0);

    // Flush under back-pressure: the last token stalls before the flush follows.
    cycle(1, 1, 0, 16'h4000, 5'd2);
    cycle(0, 0, 0, 16'h0000, 5'd0);
    cycle(1, 0, 1, 16'h5000, 5'd2);
    cycle(1, 0, 1, 16'h5000, 5'd2);
    cycle(0, 0, 1, 16'h0000, 5'd0);

    // Reset mid-frame with a held token, then two stalls and d = 3 + 2.
    cycle(1, 0, 0, 16'h6000, 5'd4);
    do_reset();
    cycle(1, 0, 0, 16'h6100, 5'd3);
    cycle(1, 0, 0, 16'h6200, 5'd9);
    cycle(1, 0, 0, 16'h6200, 5'd9);
    cycle(1, 0, 1, 16'h6300, 5'd2);
    cycle(0, 0, 1, 16'h0000, 5'd0);
    cycle(0, 0, 1, 16'h0000, 5'd0);
`ifdef STAGE_2_CTRL_STATS_EN
    check("stall_cycles", stall_cycles, 64'(m_stall));
    check("shift_total", shift_total, 64'(m_shift));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
